// File: rtl/lap_supervisor.sv
// -----------------------------------------------------------------------------
// lap_supervisor
//   Race-rule sequencer between track collision logic and main_fsm.
//   Detects rising edges on the finish-line and checkpoint overlap levels,
//   enforces in-order checkpoints, runs a prescaled lap timer, and keeps lap
//   statistics (last, best, count) for the HUD.
//
// Ports
//   pclk                  clock, rising edge
//   rst                   synchronous active-high reset
//   run                   high while the game screen is active
//   finish_hit            car overlaps finish line (level)
//   cp_hit[N_CP]          car overlaps checkpoint zone i (level)
//   lap_finished          1-cycle pulse on each finish crossing while racing
//   checkpoints_passed    all checkpoints taken in order this lap
//   max_lap_time_exceeded 1-cycle pulse on lap timeout
//   lap_time              current lap, in ticks
//   last_lap_time         last valid lap, in ticks
//   best_lap_time         fastest valid lap; all-ones when none yet
//   lap_count             valid laps completed, saturating
//   next_cp               index of the next expected checkpoint
// -----------------------------------------------------------------------------
module lap_supervisor #(
    parameter int N_CP          = 4,
    parameter int TICK_DIV      = 650000,
    parameter int MAX_LAP_TICKS = 6000,
    parameter int TIME_W        = 16,
    parameter int LAP_W         = 4
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              run,
    input  logic              finish_hit,
    input  logic [N_CP-1:0]   cp_hit,
    output logic              lap_finished,
    output logic              checkpoints_passed,
    output logic              max_lap_time_exceeded,
    output logic [TIME_W-1:0] lap_time,
    output logic [TIME_W-1:0] last_lap_time,
    output logic [TIME_W-1:0] best_lap_time,
    output logic [LAP_W-1:0]  lap_count,
    output logic [3:0]        next_cp
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRID,
        RUNNING
    } state_t;

    state_t              state_q, state_d;
    logic                prev_finish_q, prev_finish_d;
    logic [N_CP-1:0]     prev_cp_q, prev_cp_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [TIME_W-1:0]   lap_time_q, lap_time_d;
    logic [TIME_W-1:0]   last_q, last_d;
    logic [TIME_W-1:0]   best_q, best_d;
    logic [LAP_W-1:0]    lap_count_q, lap_count_d;
    logic [3:0]          next_cp_q, next_cp_d;
    logic                passed_q, passed_d;
    logic                lap_fin_q, lap_fin_d;
    logic                tout_q, tout_d;

    logic                finish_rise;
    logic [N_CP-1:0]     cp_rise;
    logic                cp_adv;
    logic                wrap;
    logic                timeout;

    always_comb begin
        state_d       = state_q;
        prev_finish_d = finish_hit;
        prev_cp_d     = cp_hit;
        presc_d       = presc_q;
        lap_time_d    = lap_time_q;
        last_d        = last_q;
        best_d        = best_q;
        lap_count_d   = lap_count_q;
        next_cp_d     = next_cp_q;
        passed_d      = passed_q;
        lap_fin_d     = 1'b0;
        tout_d        = 1'b0;

        finish_rise = finish_hit & ~prev_finish_q;
        cp_rise     = cp_hit & ~prev_cp_q;

        // Only the expected checkpoint counts; once next_cp reaches N_CP no
        // index matches, so further rises are ignored.
        cp_adv = 1'b0;
        for (int i = 0; i < N_CP; i++) begin
            if (next_cp_q == 4'(i) && cp_rise[i]) cp_adv = 1'b1;
        end

        wrap    = (presc_q == PRESC_W'(TICK_DIV - 1));
        timeout = wrap && (lap_time_q == TIME_W'(MAX_LAP_TICKS - 1));

        if (!run) begin
            state_d    = IDLE;
            presc_d    = '0;
            lap_time_d = '0;
            next_cp_d  = '0;
            passed_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d    = '0;
                    lap_time_d = '0;
                    state_d    = GRID;
                end
                GRID: begin
                    // Start crossing: begins the lap without a lap_finished pulse.
                    if (finish_rise) begin
                        state_d    = RUNNING;
                        presc_d    = '0;
                        lap_time_d = '0;
                        next_cp_d  = '0;
                        passed_d   = 1'b0;
                    end
                end
                RUNNING: begin
                    // checkpoints_passed stays valid through the lap_finished
                    // cycle so main_fsm can sample both together, then drops.
                    if (lap_fin_q) passed_d = 1'b0;

                    if (finish_rise) begin
                        // Finish beats a same-cycle timeout and cp rise.
                        lap_fin_d  = 1'b1;
                        passed_d   = passed_q;
                        if (passed_q) begin
                            last_d = lap_time_q;
                            if (lap_time_q < best_q) best_d = lap_time_q;
                            if (lap_count_q != '1) lap_count_d = lap_count_q + LAP_W'(1);
                        end
                        presc_d    = '0;
                        lap_time_d = '0;
                        next_cp_d  = '0;
                    end else if (timeout) begin
                        tout_d     = 1'b1;
                        presc_d    = '0;
                        lap_time_d = '0;
                        next_cp_d  = '0;
                        passed_d   = 1'b0;
                        state_d    = GRID;
                    end else begin
                        if (wrap) begin
                            presc_d    = '0;
                            lap_time_d = lap_time_q + TIME_W'(1);
                        end else begin
                            presc_d = presc_q + PRESC_W'(1);
                        end
                        if (cp_adv) begin
                            next_cp_d = next_cp_q + 4'd1;
                            if (next_cp_q == 4'(N_CP - 1)) passed_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q       <= IDLE;
            prev_finish_q <= 1'b0;
            prev_cp_q     <= '0;
            presc_q       <= '0;
            lap_time_q    <= '0;
            last_q        <= '0;
            best_q        <= '1;
            lap_count_q   <= '0;
            next_cp_q     <= '0;
            passed_q      <= 1'b0;
            lap_fin_q     <= 1'b0;
            tout_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_finish_q <= prev_finish_d;
            prev_cp_q     <= prev_cp_d;
            presc_q       <= presc_d;
            lap_time_q    <= lap_time_d;
            last_q        <= last_d;
            best_q        <= best_d;
            lap_count_q   <= lap_count_d;
            next_cp_q     <= next_cp_d;
            passed_q      <= passed_d;
            lap_fin_q     <= lap_fin_d;
            tout_q        <= tout_d;
        end
    end

    assign lap_finished          = lap_fin_q;
    assign checkpoints_passed    = passed_q;
    assign max_lap_time_exceeded = tout_q;
    assign lap_time              = lap_time_q;
    assign last_lap_time         = last_q;
    assign best_lap_time         = best_q;
    assign lap_count             = lap_count_q;
    assign next_cp               = next_cp_q;

endmodule

// File: tb/tb_lap_supervisor.sv
// -----------------------------------------------------------------------------
// tb_lap_supervisor
//   Self-checking bench for lap_supervisor (N_CP=3, TICK_DIV=4,
//   MAX_LAP_TICKS=20). Expected lap_finished / timeout events are queued when
//   the stimulus is driven and popped by a monitor when the pulse appears.
// -----------------------------------------------------------------------------
module tb_lap_supervisor;

    localparam int N_CP = 3;
    localparam int TICK_DIV = 4;
    localparam int MAX_LAP_TICKS = 20;
    localparam int TIME_W = 16;
    localparam int LAP_W = 4;

    logic              pclk = 1'b0;
    logic              rst;
    logic              run;
    logic              finish_hit;
    logic [N_CP-1:0]   cp_hit;
    logic              lap_finished;
    logic              checkpoints_passed;
    logic              max_lap_time_exceeded;
    logic [TIME_W-1:0] lap_time;
    logic [TIME_W-1:0] last_lap_time;
    logic [TIME_W-1:0] best_lap_time;
    logic [LAP_W-1:0]  lap_count;
    logic [3:0]        next_cp;

    typedef struct packed {
        logic        is_tout;
        logic        passed;
        logic [15:0] last;
        logic [15:0] best;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    lap_supervisor #(
        .N_CP(N_CP), .TICK_DIV(TICK_DIV), .MAX_LAP_TICKS(MAX_LAP_TICKS),
        .TIME_W(TIME_W), .LAP_W(LAP_W)
    ) dut (
        .pclk(pclk), .rst(rst), .run(run), .finish_hit(finish_hit), .cp_hit(cp_hit),
        .lap_finished(lap_finished), .checkpoints_passed(checkpoints_passed),
        .max_lap_time_exceeded(max_lap_time_exceeded), .lap_time(lap_time),
        .last_lap_time(last_lap_time), .best_lap_time(best_lap_time),
        .lap_count(lap_count), .next_cp(next_cp)
    );

    always #5 pclk = ~pclk;

    // Scoreboard monitor: every pulse must match the oldest queued expectation.
    always @(negedge pclk) begin
        if (!rst && (lap_finished || max_lap_time_exceeded)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_pulse lap_finished=%0b timeout=%0b lap_time=%0d",
                         lap_finished, max_lap_time_exceeded, lap_time);
            end else begin
                mon_e = sb.pop_front();
                if ({lap_finished, max_lap_time_exceeded, checkpoints_passed,
                     last_lap_time, best_lap_time, lap_count} !==
                    {~mon_e.is_tout, mon_e.is_tout, mon_e.passed,
                     mon_e.last, mon_e.best, mon_e.cnt}) begin
                    failures++;
                    $display("FAIL sb_event got lf=%0b to=%0b cpp=%0b last=%0d best=%0d cnt=%0d want lf=%0b to=%0b cpp=%0b last=%0d best=%0d cnt=%0d",
                             lap_finished, max_lap_time_exceeded, checkpoints_passed,
                             last_lap_time, best_lap_time, lap_count,
                             ~mon_e.is_tout, mon_e.is_tout, mon_e.passed,
                             mon_e.last, mon_e.best, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic push_exp(input logic tout, input logic passed, input logic [15:0] last,
                            input logic [15:0] best, input logic [3:0] cnt);
        exp_t e;
        e.is_tout = tout;
        e.passed  = passed;
        e.last    = last;
        e.best    = best;
        e.cnt     = cnt;
        sb.push_back(e);
    endtask

    task automatic cp_rise(input int idx);
        cp_hit      = '0;
        cp_hit[idx] = 1'b1;
        step();
        cp_hit = '0;
        step();
    endtask

    task automatic wait_lap(input int k);
        int n = 0;
        while (lap_time !== 16'(k) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (lap_time !== 16'(k)) begin
            failures++;
            $display("FAIL wait_lap timed out lap_time=%0d want=%0d", lap_time, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; finish_hit = 1'b0; cp_hit = '0;
        repeat (3) step();
        checks++;
        if ({lap_finished, checkpoints_passed, max_lap_time_exceeded, lap_time,
             last_lap_time, best_lap_time, lap_count, next_cp} !==
            {3'b000, 16'd0, 16'd0, 16'hFFFF, 4'd0, 4'd0}) begin
            failures++;
            $display("FAIL reset_state lap_time=%0d last=%0d best=%h cnt=%0d next_cp=%0d",
                     lap_time, last_lap_time, best_lap_time, lap_count, next_cp);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_start();
        run = 1'b1;
        repeat (4) step();
        finish_hit = 1'b1;
        step();
        finish_hit = 1'b0;
        checks++;
        if ({lap_time, next_cp} !== {16'd0, 4'd0}) begin
            failures++;
            $display("FAIL start_clear lap_time=%0d next_cp=%0d want 0 0", lap_time, next_cp);
        end
        repeat (3) step();
        checks++;
        if (lap_time !== 16'd0) begin
            failures++;
            $display("FAIL tick_early lap_time=%0d want 0", lap_time);
        end
        step();
        checks++;
        if (lap_time !== 16'd1) begin
            failures++;
            $display("FAIL tick_first lap_time=%0d want 1", lap_time);
        end
        repeat (4) step();
        checks++;
        if (lap_time !== 16'd2) begin
            failures++;
            $display("FAIL tick_second lap_time=%0d want 2", lap_time);
        end
    endtask

    task automatic do_clean_lap(input int target, input int exp_best, input int exp_cnt);
        cp_rise(0);
        checks++;
        if (next_cp !== 4'd1) begin
            failures++;
            $display("FAIL cp_first next_cp=%0d want 1", next_cp);
        end
        cp_rise(1);
        cp_rise(2);
        checks++;
        if ({next_cp, checkpoints_passed} !== {4'd3, 1'b1}) begin
            failures++;
            $display("FAIL cp_all next_cp=%0d passed=%0b want 3 1", next_cp, checkpoints_passed);
        end
        wait_lap(target);
        finish_hit = 1'b1;
        push_exp(1'b0, 1'b1, 16'(target), 16'(exp_best), 4'(exp_cnt));
        step();
        finish_hit = 1'b0;
        checks++;
        if ({checkpoints_passed, lap_time, next_cp} !== {1'b1, 16'd0, 4'd0}) begin
            failures++;
            $display("FAIL finish_cycle passed=%0b lap_time=%0d next_cp=%0d want 1 0 0",
                     checkpoints_passed, lap_time, next_cp);
        end
        step();
        checks++;
        if (checkpoints_passed !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL finish_after passed=%0b pending=%0d want 0 0", checkpoints_passed, sb.size());
        end
    endtask

    task automatic test_in_order_laps();
        do_clean_lap(9, 9, 1);
        do_clean_lap(7, 7, 2);
        do_clean_lap(12, 7, 3);
    endtask

    task automatic test_out_of_order();
        cp_rise(0);
        cp_rise(2);
        checks++;
        if (next_cp !== 4'd1) begin
            failures++;
            $display("FAIL cp_skip next_cp=%0d want 1", next_cp);
        end
        cp_rise(1);
        checks++;
        if ({next_cp, checkpoints_passed} !== {4'd2, 1'b0}) begin
            failures++;
            $display("FAIL cp_order next_cp=%0d passed=%0b want 2 0", next_cp, checkpoints_passed);
        end
        finish_hit = 1'b1;
        push_exp(1'b0, 1'b0, 16'd12, 16'd7, 4'd3);
        step();
        finish_hit = 1'b0;
        step();
        checks++;
        if (sb.size() != 0 || lap_count !== 4'd3) begin
            failures++;
            $display("FAIL cheat_lap pending=%0d lap_count=%0d want 0 3", sb.size(), lap_count);
        end
    endtask

    task automatic test_timeout();
        int n = 1;
        push_exp(1'b1, 1'b0, 16'd12, 16'd7, 4'd3);
        while (!max_lap_time_exceeded && n < 120) begin
            step();
            n++;
        end
        checks++;
        if (n != 80) begin
            failures++;
            $display("FAIL timeout_latency cycles=%0d want 80", n);
        end
        checks++;
        if ({lap_time, next_cp, checkpoints_passed} !== {16'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL timeout_clear lap_time=%0d next_cp=%0d passed=%0b", lap_time, next_cp, checkpoints_passed);
        end
        repeat (10) step();
        checks++;
        if (lap_time !== 16'd0 || sb.size() != 0) begin
            failures++;
            $display("FAIL grid_stopped lap_time=%0d pending=%0d want 0 0", lap_time, sb.size());
        end
        finish_hit = 1'b1;
        repeat (50) step();
        finish_hit = 1'b0;
        checks++;
        if (lap_time !== 16'd12) begin
            failures++;
            $display("FAIL held_finish_single_start lap_time=%0d want 12", lap_time);
        end
    endtask

    task automatic test_simultaneous_and_run_drop();
        wait_lap(19);
        repeat (3) step();
        finish_hit = 1'b1;
        push_exp(1'b0, 1'b0, 16'd12, 16'd7, 4'd3);
        step();
        finish_hit = 1'b0;
        repeat (4) step();
        checks++;
        if (lap_time !== 16'd1) begin
            failures++;
            $display("FAIL finish_beats_timeout lap_time=%0d want 1", lap_time);
        end
        step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL finish_beats_timeout_pulse pending=%0d want 0", sb.size());
        end
        cp_rise(0);
        run = 1'b0;
        step();
        checks++;
        if ({lap_time, next_cp, checkpoints_passed, last_lap_time, best_lap_time, lap_count} !==
            {16'd0, 4'd0, 1'b0, 16'd12, 16'd7, 4'd3}) begin
            failures++;
            $display("FAIL run_drop lap_time=%0d next_cp=%0d passed=%0b last=%0d best=%0d cnt=%0d",
                     lap_time, next_cp, checkpoints_passed, last_lap_time, best_lap_time, lap_count);
        end
    endtask

    task automatic test_held_finish_and_rst();
        finish_hit = 1'b1;
        repeat (3) step();
        run = 1'b1;
        repeat (12) step();
        checks++;
        if (lap_time !== 16'd0) begin
            failures++;
            $display("FAIL held_before_run lap_time=%0d want 0", lap_time);
        end
        finish_hit = 1'b0;
        step();
        finish_hit = 1'b1;
        step();
        finish_hit = 1'b0;
        repeat (8) step();
        checks++;
        if (lap_time !== 16'd2) begin
            failures++;
            $display("FAIL restart_after_fall lap_time=%0d want 2", lap_time);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({lap_time, last_lap_time, best_lap_time, lap_count, next_cp, checkpoints_passed} !==
            {16'd0, 16'd0, 16'hFFFF, 4'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL rst_mid_lap lap_time=%0d last=%0d best=%h cnt=%0d", lap_time, last_lap_time, best_lap_time, lap_count);
        end
        rst = 1'b0;
        repeat (8) step();
        checks++;
        if (lap_time !== 16'd0 || sb.size() != 0) begin
            failures++;
            $display("FAIL after_rst lap_time=%0d pending=%0d want 0 0", lap_time, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_in_order_laps();
        test_out_of_order();
        test_timeout();
        test_simultaneous_and_run_drop();
        test_held_finish_and_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
